// File: rtl/noc_output_port_vc_if.sv
// Crossbar-side and link-side signals of the NoC output port.
// The slave modport is the port itself; the master modport is the crossbar/link environment.
interface noc_output_port_vc_if #(
  parameter int WIDTH  = 16,
  parameter int NUM_VC = 2,
  parameter int VCW    = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
);
  logic [WIDTH-1:0]  data_i;
  logic [VCW-1:0]    vc_i;
  logic              port_en;
  logic [NUM_VC-1:0] inc_credit_i;
  logic [WIDTH-1:0]  data_o;
  logic [VCW-1:0]    vc_o;
  logic              send_data;
  logic [NUM_VC-1:0] full;
  logic              err_o;

  modport master (
    output data_i, vc_i, port_en, inc_credit_i,
    input  data_o, vc_o, send_data, full, err_o
  );

  modport slave (
    input  data_i, vc_i, port_en, inc_credit_i,
    output data_o, vc_o, send_data, full, err_o
  );
endinterface

// File: rtl/noc_output_port_vc.sv
// Credit-based NoC output port: per-VC FIFOs, round-robin VC arbitration, registered link output.
// Optional feature: define NOC_OUTPORT_ERR_EN for the sticky err_o flag and overflow assertions.
module noc_output_port_vc #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 5,
  parameter int NUM_VC  = 2,
  parameter int CREDITS = 5,
  parameter int VCW     = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input logic                 clk,
  input logic                 rst_n,
  noc_output_port_vc_if.slave bus
);
  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int CRW  = $clog2(CREDITS + 1);

  logic [WIDTH-1:0]  mem       [NUM_VC][DEPTH];
  logic [PTRW-1:0]   wr_ptr    [NUM_VC];
  logic [PTRW-1:0]   rd_ptr    [NUM_VC];
  logic [CNTW-1:0]   count     [NUM_VC];
  logic [CNTW-1:0]   count_nxt [NUM_VC];
  logic [CRW-1:0]    credit    [NUM_VC];
  logic [NUM_VC-1:0] full_q;
  logic [VCW-1:0]    rr_ptr;

  logic [NUM_VC-1:0] push_sel;
  logic [NUM_VC-1:0] pop_sel;
  logic [NUM_VC-1:0] eligible;
  logic              grant_valid;
  logic [VCW-1:0]    grant_vc;
  int                cand;

  logic [WIDTH-1:0]  data_q;
  logic [VCW-1:0]    vc_q;
  logic              send_q;

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Push is gated by the registered full flag, so a same-cycle pop never frees room for a push.
  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    push_sel    = '0;
    pop_sel     = '0;
    eligible    = '0;
    grant_valid = 1'b0;
    grant_vc    = '0;
    cand        = 0;
    for (int v = 0; v < NUM_VC; v++) begin
      push_sel[v] = bus.port_en && (int'(bus.vc_i) == v) && !full_q[v];
      eligible[v] = (count[v] != '0) && (credit[v] != '0);
    end
    for (int off = 0; off < NUM_VC; off++) begin
      cand = (int'(rr_ptr) + off) % NUM_VC;
      if (!grant_valid && eligible[cand]) begin
        grant_valid = 1'b1;
        grant_vc    = VCW'(cand);
      end
    end
    if (grant_valid) pop_sel[grant_vc] = 1'b1;
  end

  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      count_nxt[v] = count[v] + CNTW'(push_sel[v]) - CNTW'(pop_sel[v]);
    end
  end

  // NOTE: flit storage is not reset; the occupancy counters alone decide which entries are valid.
  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VC; v++) begin
      if (push_sel[v]) mem[v][wr_ptr[v]] <= bus.data_i;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VC; v++) begin
        wr_ptr[v] <= '0;
        rd_ptr[v] <= '0;
        count[v]  <= '0;
        credit[v] <= CRW'(CREDITS);
      end
      full_q <= '0;
      rr_ptr <= '0;
      data_q <= '0;
      vc_q   <= '0;
      send_q <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (push_sel[v]) wr_ptr[v] <= ptr_inc(wr_ptr[v]);
        if (pop_sel[v])  rd_ptr[v] <= ptr_inc(rd_ptr[v]);
        count[v]  <= count_nxt[v];
        full_q[v] <= (count_nxt[v] == CNTW'(DEPTH));
        // Return and consume together cancel; a lone return at the limit saturates.
        if (bus.inc_credit_i[v] && !pop_sel[v]) begin
          if (credit[v] != CRW'(CREDITS)) credit[v] <= credit[v] + 1'b1;
        end else if (!bus.inc_credit_i[v] && pop_sel[v]) begin
          credit[v] <= credit[v] - 1'b1;
        end
      end
      send_q <= grant_valid;
      if (grant_valid) begin
        data_q <= mem[grant_vc][rd_ptr[grant_vc]];
        vc_q   <= grant_vc;
        rr_ptr <= (int'(grant_vc) == NUM_VC - 1) ? '0 : grant_vc + 1'b1;
      end
    end
  end

  assign bus.data_o    = data_q;
  assign bus.vc_o      = vc_q;
  assign bus.send_data = send_q;
  assign bus.full      = full_q;

`ifdef NOC_OUTPORT_ERR_EN
  logic              drop_evt;
  logic              sat_evt;
  logic              err_q;
  logic [NUM_VC-1:0] at_max;

  always_comb begin
    at_max = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      at_max[v] = (credit[v] == CRW'(CREDITS));
    end
  end

  assign drop_evt = bus.port_en && (push_sel == '0);
  assign sat_evt  = |(bus.inc_credit_i & ~pop_sel & at_max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   err_q <= 1'b0;
    else if (drop_evt || sat_evt) err_q <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!drop_evt) else $warning("flit pushed to a full VC was dropped");
      assert (!sat_evt)  else $warning("credit returned to a VC already at its limit");
    end
  end

  assign bus.err_o = err_q;
`else
  assign bus.err_o = 1'b0;
`endif
endmodule

// File: doc/noc_output_port_vc.md
# noc_output_port_vc

Credit-based NoC router output port with per-virtual-channel buffering. Accepts flits from the crossbar into one of `NUM_VC` FIFOs, arbitrates round-robin among VCs that hold data and downstream credit, and launches one registered flit per cycle onto the link. Sits between the router crossbar and the inter-router link; the downstream input port returns credits per VC.

## Interface
- `WIDTH`, 16: flit width in bits.
- `DEPTH`, 5: entries per VC FIFO (≥2).
- `NUM_VC`, 2: virtual channel count (≥1); `VCW = max(1, $clog2(NUM_VC))`.
- `CREDITS`, 5: downstream buffer slots per VC; initial and maximum credit count.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `data_i`  in  WIDTH  flit from crossbar.
- `vc_i`  in  VCW  target VC of `data_i`.
- `port_en`  in  1  push request for `data_i` into FIFO `vc_i`.
- `inc_credit_i`  in  NUM_VC  one-hot-per-bit credit return; bit v returns one credit for VC v.
- `data_o`  out  WIDTH  flit on link.
- `vc_o`  out  VCW  VC tag of `data_o`.
- `send_data`  out  1  `data_o`/`vc_o` valid this cycle.
- `full`  out  NUM_VC  bit v high when FIFO v holds `DEPTH` entries.
- `err_o`  out  1  sticky protocol-error flag (see Configuration).

## Operation
- Reset (async assert): all FIFOs empty, all credit counters = `CREDITS`, RR pointer = VC 0, `data_o`=0, `vc_o`=0, `send_data`=0, `full`=0, `err_o`=0.
- Push: `port_en && !full[vc_i]` writes `data_i` to FIFO `vc_i`. `port_en` with `full[vc_i]` high: flit dropped, no state change besides error flag.
- Eligibility: VC v eligible when FIFO v non-empty and credit[v] ≠ 0.
- Arbitration: round-robin starting at RR pointer; grant lowest eligible index at or after pointer, wrapping. After a grant to v, pointer = (v+1) mod NUM_VC. No grant → pointer unchanged.
- Pop: granted VC pops head; credit[v] decrements; flit and VC registered onto `data_o`/`vc_o`, `send_data`=1 next cycle. No grant → `send_data`=0, `data_o`/`vc_o` hold last values.
- Credit arithmetic per VC: counter width `$clog2(CREDITS+1)`. Simultaneous return and consume on the same VC → unchanged. Return while counter = `CREDITS` and no consume → saturate at `CREDITS` (error). Counter never underflows (consume requires credit ≠ 0).
- FIFO: circular, pointers wrap at `DEPTH` (non-power-of-two supported), occupancy counter `$clog2(DEPTH+1)` bits. Simultaneous push and pop on the same VC → occupancy unchanged, legal even when full? No: push gated by registered `full`, so push to a full FIFO is rejected even if same-cycle pop occurs.

## Timing
- Push-to-link latency: minimum 2 cycles (write at edge N, arbitrated cycle N+1, `send_data` high after edge N+1).
- Throughput: one flit per cycle across all VCs; each VC sustains 1 flit/cycle when sole eligible and credits available.
- `full` is registered from occupancy; reflects pushes/pops of the previous edge.
- Credit returned at edge N makes VC eligible in cycle N+1.
- Reset deassertion mid-traffic: in-flight flits discarded; first push accepted on first edge with `rst_n` high.

## Configuration
- `NOC_OUTPORT_ERR_EN`: defined → `err_o` sets (sticky until reset) on push to full FIFO or credit return at `CREDITS`; simulation assertions fire on same events. Undefined → error logic omitted, `err_o` tied 0, overflow cases still dropped/saturated as above.

## Test plan
- Reset: drive `rst_n`=0 mid-cycle → all outputs 0 immediately; release, push flit 0x1234 on VC0 → `send_data`=1, `data_o`=0x1234, `vc_o`=0 two cycles after push.
- Credit exhaustion: NUM_VC=2, push 7 flits VC0 with no returns → exactly 5 sent, `full[0]`=0 after drain to 2; return 2 credits → remaining 2 sent.
- Round-robin: both VCs loaded with 4 flits, ample credit → `vc_o` sequence 0,1,0,1,0,1,0,1, `send_data` continuous.
- Full/drop: credits 0 on VC1, push 6 flits → `full[1]`=1 after 5th, 6th dropped; `err_o`=1 with macro, 0 without.
- Credit saturation: return credit on VC0 at 5 → counter stays 5, `err_o`=1 (macro); simultaneous return+send at 3 → stays 3.
- Wrap-around: DEPTH=5, 20 flits streamed through VC0 with returns → data order preserved, values 0..19.
